// File: rtl/x_mux_sched.sv
`default_nettype none
// ============================================================================
// Module   : x_mux_sched
// Purpose  : Round-robin scheduler for two requesters sharing a double-rate
//            output mux. Each granted word is split into two time slices
//            (din1st/din2nd) qualified by a registered output enable.
// Revision : 1.0 - initial release
// ============================================================================
module x_mux_sched #(
  parameter int WIDTH    = 8,
  parameter int MAXBURST = 4,
  parameter int TURN     = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [1:0]       last,
  input  logic [WIDTH-1:0] data0_1st,
  input  logic [WIDTH-1:0] data0_2nd,
  input  logic [WIDTH-1:0] data1_1st,
  input  logic [WIDTH-1:0] data1_2nd,
  input  logic             cnt_clr,
  output logic [1:0]       gnt,
  output logic [1:0]       ack,
  output logic [WIDTH-1:0] din1st,
  output logic [WIDTH-1:0] din2nd,
  output logic             oe,
  output logic             busy,
  output logic [15:0]      xfer_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_TURN = 2'd2
  } state_t;

  // Burst ends on the transfer that brings the burst count to MAXBURST words
  localparam logic [3:0] C_BURST_END = 4'(MAXBURST - 1);
  localparam logic [1:0] C_TURN_END  = 2'(TURN - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_gnt;
  logic             r_last_srv;   // index of the requester served most recently
  logic [3:0]       r_burst;
  logic [1:0]       r_turn_cnt;
  logic [WIDTH-1:0] r_din1st;
  logic [WIDTH-1:0] r_din2nd;
  logic             r_oe;
  logic [15:0]      r_xfer_cnt;

  logic [1:0]       w_ack;
  logic             w_xfer;
  logic             w_last;
  logic             w_pick;
  logic             w_grant;
  logic             w_release;

  // Tie goes to the requester not served last; a lone request always wins
  assign w_pick    = (req == 2'b11) ? ~r_last_srv : req[1];
  assign w_xfer    = |w_ack;
  assign w_last    = |(w_ack & last);
  assign w_grant   = (r_state == S_IDLE) && (w_state_nxt == S_SEND);
  assign w_release = (r_state == S_SEND) && (w_state_nxt == S_TURN);

  // Consume strobe: only the owner, only while sending, never under reset
  always_comb begin
    w_ack = 2'b00;
    if (!reset && (r_state == S_SEND)) begin
      w_ack = r_gnt & req;
    end
  end

  // Next-state: a burst closes on last, on the word limit, or when the owner drops req
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (req != 2'b00) w_state_nxt = S_SEND;
      S_SEND:  if (!w_xfer || w_last || (r_burst == C_BURST_END)) w_state_nxt = S_TURN;
      S_TURN:  if (r_turn_cnt == C_TURN_END) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant, round-robin history, burst and turnaround counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_gnt      <= 2'b00;
      r_last_srv <= 1'b1;
      r_burst    <= 4'd0;
      r_turn_cnt <= 2'd0;
    end else begin
      if (w_xfer) begin
        r_burst <= r_burst + 4'd1;
      end
      if (w_grant) begin
        r_gnt   <= w_pick ? 2'b10 : 2'b01;
        r_burst <= 4'd0;
      end else if (w_release) begin
        r_gnt      <= 2'b00;
        r_last_srv <= r_gnt[1];
        r_turn_cnt <= 2'd0;
      end
      if (r_state == S_TURN) begin
        r_turn_cnt <= r_turn_cnt + 2'd1;
      end
    end
  end

  // Mux-side registers: slices and enable follow the consumed word, zero otherwise
  always_ff @(posedge clock) begin
    if (reset || !w_xfer) begin
      r_oe     <= 1'b0;
      r_din1st <= '0;
      r_din2nd <= '0;
    end else begin
      r_oe     <= 1'b1;
      r_din1st <= r_gnt[1] ? data1_1st : data0_1st;
      r_din2nd <= r_gnt[1] ? data1_2nd : data0_2nd;
    end
  end

  // Saturating transfer counter; clear wins over a same-cycle increment
  always_ff @(posedge clock) begin
    if (reset || cnt_clr) begin
      r_xfer_cnt <= 16'd0;
    end else if (w_xfer && (r_xfer_cnt != 16'hFFFF)) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign gnt      = r_gnt;
  assign ack      = w_ack;
  assign din1st   = r_din1st;
  assign din2nd   = r_din2nd;
  assign oe       = r_oe;
  assign busy     = !reset && (r_state != S_IDLE);
  assign xfer_cnt = r_xfer_cnt;

endmodule
`default_nettype wire
